// File: rtl/io_ccff_pkg.sv
// Shared state encoding and default sizes for the IO-tile configuration chain loader.
package io_ccff_pkg;

   localparam int CHAIN_LEN_DEF = 64;
   localparam int WORD_W_DEF    = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_LOAD  = 2'd2,
      ST_DONE  = 2'd3
   } ccff_state_t;

endpackage

// File: rtl/io_ccff_shifter.sv
// Word buffer for the configuration chain: holds one bitstream word and
// presents it LSB first on the chain head, one bit per enabled cycle.
module io_ccff_shifter
   import io_ccff_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF,
   parameter int BW     = $clog2(WORD_W + 1)
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              enable,
   input  logic              flush,
   input  logic              load,
   input  logic [WORD_W-1:0] data,
   output logic [BW-1:0]     bits_left,
   output logic              head,
   output logic              shift_en
);

   logic [WORD_W-1:0] word_q;

   assign shift_en = enable && (bits_left != '0);
   assign head     = shift_en && word_q[0];

   // A load on the cycle the final bit is presented replaces it seamlessly.
   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         word_q    <= '0;
         bits_left <= '0;
      end else if (flush) begin
         word_q    <= '0;
         bits_left <= '0;
      end else if (load) begin
         word_q    <= data;
         bits_left <= BW'(WORD_W);
      end else if (shift_en) begin
         word_q    <= word_q >> 1;
         bits_left <= bits_left - BW'(1);
      end
   end

endmodule

// File: rtl/io_ccff_loader.sv
// Streams a bitstream into the IO-tile configuration flip-flop chain while the pads are isolated.
// Build option: define IO_CCFF_CLEAR_EN to shift CHAIN_LEN zeros through the chain before loading.
//
// state    | meaning
// ST_IDLE  | after reset; pads isolated, waiting for start
// ST_CLEAR | flushing the chain with zeros (IO_CCFF_CLEAR_EN only)
// ST_LOAD  | accepting words and shifting bits into the chain
// ST_DONE  | chain fully loaded; pads released, waiting for start
module io_ccff_loader
   import io_ccff_pkg::*;
#(
   parameter int CHAIN_LEN = CHAIN_LEN_DEF,
   parameter int WORD_W    = WORD_W_DEF
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   output logic              IO_ISOL_N,
   output logic              busy,
   output logic              done
);

   localparam int            CW  = $clog2(CHAIN_LEN + 1);
   localparam int            BW  = $clog2(WORD_W + 1);
   localparam logic [CW-1:0] LEN = CW'(CHAIN_LEN);

   ccff_state_t   state;
   logic [CW-1:0] bits_rem;
   logic [BW-1:0] bits_left;
   logic          sh_head;
   logic          sh_shift_en;
   logic          in_load;
   logic          last_shift;
   logic          accept;
   logic          clear_act;

   assign in_load    = (state == ST_LOAD);
   assign last_shift = in_load && sh_shift_en && (bits_rem == CW'(1));
   // bits_rem counts down chain positions still to fill; buffered bits must fit in it.
   assign cfg_ready  = in_load && (bits_left <= BW'(1)) && (32'(bits_left) < 32'(bits_rem));
   assign accept     = cfg_valid && cfg_ready;

`ifdef IO_CCFF_CLEAR_EN
   assign clear_act = (state == ST_CLEAR);
`else
   assign clear_act = 1'b0;
`endif

   assign ccff_shift_en = clear_act || sh_shift_en;
   assign ccff_head     = sh_head;

   io_ccff_shifter #(
      .WORD_W (WORD_W),
      .BW     (BW)
   ) u_shifter (
      .prog_clk  (prog_clk),
      .pReset    (pReset),
      .enable    (in_load),
      .flush     (!in_load || last_shift),
      .load      (accept),
      .data      (cfg_data),
      .bits_left (bits_left),
      .head      (sh_head),
      .shift_en  (sh_shift_en)
   );

   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         state     <= ST_IDLE;
         bits_rem  <= '0;
         IO_ISOL_N <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  bits_rem  <= LEN;
                  IO_ISOL_N <= 1'b0;
                  busy      <= 1'b1;
`ifdef IO_CCFF_CLEAR_EN
                  state     <= ST_CLEAR;
`else
                  state     <= ST_LOAD;
`endif
               end
            end
            ST_CLEAR: begin
               if (bits_rem == CW'(1)) begin
                  state    <= ST_LOAD;
                  bits_rem <= LEN;
               end else begin
                  bits_rem <= bits_rem - CW'(1);
               end
            end
            ST_LOAD: begin
               if (sh_shift_en) begin
                  if (bits_rem == CW'(1)) begin
                     state     <= ST_DONE;
                     bits_rem  <= '0;
                     done      <= 1'b1;
                     IO_ISOL_N <= 1'b1;
                     busy      <= 1'b0;
                  end else begin
                     bits_rem <= bits_rem - CW'(1);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_io_ccff_loader.sv
// Directed bench for io_ccff_loader (CHAIN_LEN=20, WORD_W=8); follows IO_CCFF_CLEAR_EN if defined.
module tb_io_ccff_loader;

   localparam int N = 20;
   localparam int W = 8;
`ifdef IO_CCFF_CLEAR_EN
   localparam int CLR = N;
`else
   localparam int CLR = 0;
`endif

   logic         prog_clk = 1'b0;
   logic         pReset;
   logic         start;
   logic [W-1:0] cfg_data;
   logic         cfg_valid;
   logic         cfg_ready;
   logic         ccff_head;
   logic         ccff_shift_en;
   logic         IO_ISOL_N;
   logic         busy;
   logic         done;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic         start;
      logic         valid;
      logic [W-1:0] data;
      logic         ready;
      logic         shift;
      logic         head;
      logic         isol;
      logic         busy;
      logic         done;
   } vec_t;

   vec_t tbl[$];

   always #5 prog_clk = ~prog_clk;

   io_ccff_loader #(
      .CHAIN_LEN (N),
      .WORD_W    (W)
   ) dut (
      .prog_clk      (prog_clk),
      .pReset        (pReset),
      .start         (start),
      .cfg_data      (cfg_data),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .ccff_head     (ccff_head),
      .ccff_shift_en (ccff_shift_en),
      .IO_ISOL_N     (IO_ISOL_N),
      .busy          (busy),
      .done          (done)
   );

   task automatic chk(input string name, input int cyc, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int cyc, input logic rd, input logic hd,
                          input logic sh, input logic iso, input logic bz, input logic dn);
      chk({tag, ".ready"}, cyc, cfg_ready, rd);
      chk({tag, ".head"},  cyc, ccff_head, hd);
      chk({tag, ".shift"}, cyc, ccff_shift_en, sh);
      chk({tag, ".isol"},  cyc, IO_ISOL_N, iso);
      chk({tag, ".busy"},  cyc, busy, bz);
      chk({tag, ".done"},  cyc, done, dn);
   endtask

   task automatic do_reset();
      pReset    = 1'b1;
      start     = 1'b0;
      cfg_valid = 1'b0;
      cfg_data  = '0;
      @(posedge prog_clk);
      #1;
      chk_all("rst", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      pReset = 1'b0;
      @(negedge prog_clk);
      chk_all("rst_rel", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge prog_clk);
      #1;
   endtask

   // Masks are indexed by load-relative cycle; the clear phase, when built in, is spliced after cycle 0.
   task automatic build(input logic [31:0] st_m, input logic [31:0] vl_m, input logic [31:0] rd_m,
                        input logic [31:0] sh_m, input logic [31:0] bz_m, input logic [31:0] dn_m,
                        input int len);
      logic [19:0]  hv;
      logic [W-1:0] words [3];
      logic         iso;
      int           k;
      int           w;
      hv    = 20'h63CA5;
      words = '{8'hA5, 8'h3C, 8'h96};
      iso   = 1'b0;
      k     = 0;
      w     = 0;
      tbl.delete();
      for (int c = 0; c < len + CLR; c++) begin
         vec_t v;
         int   m;
         if (c >= 1 && c <= CLR) begin
            v = '{start: 1'b0, valid: 1'b1, data: words[0], ready: 1'b0, shift: 1'b1,
                  head: 1'b0, isol: 1'b0, busy: 1'b1, done: 1'b0};
         end else begin
            m = (c == 0) ? 0 : c - CLR;
            if (dn_m[m]) iso = 1'b1;
            v.start = st_m[m];
            v.valid = vl_m[m];
            v.data  = (w < 3) ? words[w] : 8'hFF;
            v.ready = rd_m[m];
            v.shift = sh_m[m];
            v.head  = sh_m[m] ? hv[k] : 1'b0;
            v.isol  = iso;
            v.busy  = bz_m[m];
            v.done  = dn_m[m];
            if (sh_m[m]) k++;
            if (rd_m[m] && vl_m[m]) w++;
         end
         tbl.push_back(v);
      end
   endtask

   task automatic run_tbl(input string tag);
      int shifts;
      shifts = 0;
      for (int i = 0; i < tbl.size(); i++) begin
         start     = tbl[i].start;
         cfg_valid = tbl[i].valid;
         cfg_data  = tbl[i].data;
         @(negedge prog_clk);
         chk_all(tag, i, tbl[i].ready, tbl[i].head, tbl[i].shift, tbl[i].isol, tbl[i].busy, tbl[i].done);
         if (ccff_shift_en && !(i >= 1 && i <= CLR)) shifts++;
         @(posedge prog_clk);
         #1;
      end
      start     = 1'b0;
      cfg_valid = 1'b0;
      chk_int({tag, ".shifts"}, shifts, N);
   endtask

   initial begin
      pReset    = 1'b1;
      start     = 1'b0;
      cfg_valid = 1'b0;
      cfg_data  = '0;
      #1;
      chk_all("por", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      do_reset();

      // valid held high: words at 1, 9, 17; shifts 2..21; done at 22
      build(32'h1, 32'hFFFF_FFFF, 32'h0002_0202, 32'h003F_FFFC, 32'h003F_FFFE, 32'h0040_0000, 24);
      run_tbl("held");

      do_reset();
      // valid dropped on 5..12: bubble on 10..13, words at 1, 13, 21; done at 26
      build(32'h1, ~32'h0000_1FE0, 32'h0020_3E02, 32'h03FF_C3FC, 32'h03FF_FFFE, 32'h0400_0000, 28);
      run_tbl("bubble");

      do_reset();
      // extra start at cycle 4 is ignored while busy
      build(32'h11, 32'hFFFF_FFFF, 32'h0002_0202, 32'h003F_FFFC, 32'h003F_FFFE, 32'h0040_0000, 24);
      run_tbl("restart_ign");

      // reset at cycle 7 of a load, then a fresh load from bit 0
      do_reset();
      cfg_valid = 1'b1;
      cfg_data  = 8'hA5;
      for (int c = 0; c < 7; c++) begin
         start = (c == 0);
         @(negedge prog_clk);
         if (c == 6) begin
            chk("abort.pre_shift", c, ccff_shift_en, 1'b1);
            chk("abort.pre_busy",  c, busy, 1'b1);
         end
         @(posedge prog_clk);
         #1;
      end
      start  = 1'b0;
      pReset = 1'b1;
      #1;
      chk_all("abort", 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      do_reset();
      build(32'h1, 32'hFFFF_FFFF, 32'h0002_0202, 32'h003F_FFFC, 32'h003F_FFFE, 32'h0040_0000, 24);
      run_tbl("reload");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
